fp_operand_unpack_pipe: RTL
===========================

// Module: fp_operand_unpack_pipe
// PURPOSE
//   Registered, handshaked successor to the combinational IEEE754 operand decoder.
//   Accepts an operand pair (A,B) plus op code, and classifies each operand.
//   Emits sign, widened exponent, mantissa with explicit hidden bit, and class flags.
//   Sits between the FPU issue stage and the sqrt/div datapaths.
//   Supports two formats, selected per transaction: narrow (single) and wide (double).
// PARAMETERS
//   S_EXP_W   8    narrow-format exponent width
//   S_MAN_W   23   narrow-format stored mantissa width
//   D_EXP_W   11   wide-format exponent width
//   D_MAN_W   52   wide-format stored mantissa width
//   OP_BITS   2    op-code width; op[1] is the format bit: 0 = narrow, 1 = wide
//   Derived:  W = 1+D_EXP_W+D_MAN_W;  XW = D_EXP_W+2;  MW = D_MAN_W+1
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        async active-low reset
//   in_valid   in   1        input beat valid
//   in_ready   out  1        block can accept a beat
//   in_op      in   OP_BITS  operation code (carried through unchanged)
//   in_a       in   W        operand A; narrow format occupies bits [S_EXP_W+S_MAN_W:0]
//   in_b       in   W        operand B; same packing as in_a
//   out_valid  out  1        output beat valid
//   out_ready  in   1        downstream accepts the output beat
//   out_op     out  OP_BITS  registered copy of in_op
//   out_sign_a out  1        sign of A (1 = negative); out_sign_b is the same for B
//   out_exp_a  out  XW       signed two's-complement biased exponent of A; out_exp_b for B
//   out_man_a  out  MW       {hidden bit, mantissa}, zero-extended in narrow mode; out_man_b for B
//   out_flg_a  out  3        class of A; out_flg_b for B
//                            000 denormal, 001 zero, 010 inf, 011 nan, 100 normal
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - All out_* registers clear to 0.
//     - State goes to IDLE; in_ready=0 while rst_n is low.
//   States: IDLE/HOLD (output register empty or full) and NORM (macro builds only).
//   in_ready = rst_n & (state!=NORM) & (!out_valid | out_ready).
//   Acceptance happens on a cycle with in_valid & in_ready.
//     - Decode is registered; out_valid rises the next cycle (latency 1).
//     - Full throughput: 1 beat/cycle when out_ready=1.
//   Backpressure: with out_valid=1 and out_ready=0, all out_* hold stable and in_ready=0.
//   out_valid falls after an out_ready handshake, unless a new beat is accepted in the same cycle.
//   Classification per operand, in priority order (E = exponent field, M = mantissa field):
//     - E==0 & M==0         -> zero      (001)
//     - E==all1 & M==0      -> inf       (010)
//     - E==all1 & M!=0      -> nan       (011)
//     - E==0                -> denormal  (000)
//     - otherwise           -> normal    (100)
//   Hidden bit = |E, at bit position S_MAN_W (narrow) or D_MAN_W (wide).
//   Exponent output: zero-extended E, except a denormal uses effective exponent 1.
//   Narrow mode: bits above bit S_EXP_W+S_MAN_W of in_a/in_b are ignored.
//   Zero and denormal keep their sign bit.
// CONFIGURATION
//   Macro FP_UNPACK_DENORM_NORM_EN
//   Undefined: denormals are emitted un-normalised (exp=1, hidden=0); no NORM state.
//   Defined: an accepted beat containing a denormal enters NORM (out_valid=0, in_ready=0).
//     - Each NORM cycle shifts every still-denormal mantissa left by 1 and decrements its exp.
//     - Shifting stops per operand once its hidden-bit position is 1.
//     - On the last shift edge: out_valid=1, state returns to IDLE/HOLD.
//     - Latency = 1 + max(k_a, k_b), where k is the shift count.
//     - Flags stay 000.
//     - Beats with no denormal keep latency 1.
//     - rst_n low during NORM aborts the beat; no output is produced.
// TESTING
//   1 wide: A=0x3FF0000000000000, B=0xFFF0000000000000
//     -> next cycle flg_a=100, exp_a=0x3FF, man_a=0x10000000000000; flg_b=010, sign_b=1
//   2 narrow: A=0x7FC00000, B=0x80000000
//     -> flg_a=011, man_a=0x0000000C00000; flg_b=001, sign_b=1, exp_b=0
//   3 three back-to-back beats with out_ready=1
//     -> out_valid held high 3 cycles, outputs in order, in_ready never drops
//   4 out_ready=0 for 4 cycles with beat queued
//     -> in_ready=0, out_* stable; out_ready=1 -> queued beat appears next cycle
//   5 wide A=0x0000000000000001
//     -> macro off: flg=000, exp=1, man=1, latency 1
//     -> macro on:  man=0x10000000000000, exp=-51 (XW bits), out_valid 53 cycles after accept
//   6 macro on: assert rst_n=0 at NORM cycle 10
//     -> out_valid=0 immediately; after release in_ready=1, next beat decodes normally

Source files
------------

// File: rtl/fp_operand_unpack_pipe.sv
// -----------------------------------------------------------------------------
// fp_operand_unpack_pipe
//
// Registered and handshaked IEEE754 operand decoder. It sits between the FPU
// issue stage and the sqrt/div datapaths. Each beat carries an operand pair
// (A, B) and an op code. Both operands are classified, and their sign,
// widened exponent and explicit-hidden-bit mantissa are registered. The
// format is chosen per beat by op[1]: 0 = narrow (single), 1 = wide (double).
//
// Optional feature (macro FP_UNPACK_DENORM_NORM_EN):
//   Undefined - denormals leave with exponent 1 and hidden bit 0.
//   Defined   - a beat that holds a denormal spends extra cycles in NORM.
//               Each cycle shifts every still-denormal mantissa left by one
//               and decrements its exponent, until the hidden-bit position
//               is 1. Beats without a denormal keep latency 1.
//
// Ports
//   clk, rst_n              rising-edge clock, async active-low reset
//   in_valid / in_ready     input handshake
//   in_op  [OP_BITS]        op code, carried through to out_op
//   in_a, in_b [W]          operands; narrow format uses bits [S_EXP_W+S_MAN_W:0]
//   out_valid / out_ready   output handshake
//   out_op [OP_BITS]        registered op code
//   out_sign_{a,b}          operand sign (1 = negative)
//   out_exp_{a,b} [XW]      two's-complement biased exponent
//   out_man_{a,b} [MW]      {hidden bit, mantissa}, zero-extended in narrow mode
//   out_flg_{a,b} [3]       000 denormal, 001 zero, 010 inf, 011 nan, 100 normal
// -----------------------------------------------------------------------------
module fp_operand_unpack_pipe #(
  parameter  int unsigned S_EXP_W = 8,
  parameter  int unsigned S_MAN_W = 23,
  parameter  int unsigned D_EXP_W = 11,
  parameter  int unsigned D_MAN_W = 52,
  parameter  int unsigned OP_BITS = 2,
  localparam int unsigned W       = 1 + D_EXP_W + D_MAN_W,
  localparam int unsigned XW      = D_EXP_W + 2,
  localparam int unsigned MW      = D_MAN_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_BITS-1:0] in_op,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_BITS-1:0] out_op,
  output logic               out_sign_a,
  output logic               out_sign_b,
  output logic [XW-1:0]      out_exp_a,
  output logic [XW-1:0]      out_exp_b,
  output logic [MW-1:0]      out_man_a,
  output logic [MW-1:0]      out_man_b,
  output logic [2:0]         out_flg_a,
  output logic [2:0]         out_flg_b
);

  localparam logic [2:0] FLG_DEN  = 3'b000;
  localparam logic [2:0] FLG_ZERO = 3'b001;
  localparam logic [2:0] FLG_INF  = 3'b010;
  localparam logic [2:0] FLG_NAN  = 3'b011;
  localparam logic [2:0] FLG_NORM = 3'b100;

  localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic          sign;
    logic [XW-1:0] exp;
    logic [MW-1:0] man;
    logic [2:0]    flg;
  } dec_t;

`ifdef FP_UNPACK_DENORM_NORM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_NORM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD} state_t;
`endif

  // Combinational decode of one operand. Narrow fields are zero-extended into
  // the wide field widths, so the classification below is shared.
  function automatic dec_t f_decode(input logic [W-1:0] v, input logic wide);
    dec_t               d;
    logic [D_EXP_W-1:0] e;
    logic [D_MAN_W-1:0] m;
    logic               e_zero;
    logic               e_ones;
    logic               m_zero;
    d = '0;
    if (wide) begin
      e      = v[D_MAN_W +: D_EXP_W];
      m      = v[D_MAN_W-1:0];
      d.sign = v[W-1];
      e_ones = &v[D_MAN_W +: D_EXP_W];
    end else begin
      e      = {{(D_EXP_W-S_EXP_W){1'b0}}, v[S_MAN_W +: S_EXP_W]};
      m      = {{(D_MAN_W-S_MAN_W){1'b0}}, v[S_MAN_W-1:0]};
      d.sign = v[S_EXP_W+S_MAN_W];
      e_ones = &v[S_MAN_W +: S_EXP_W];
    end
    e_zero = (e == '0);
    m_zero = (m == '0);
    // Hidden bit lands at D_MAN_W (wide) or S_MAN_W (narrow).
    if (wide) d.man = {~e_zero, m};
    else      d.man = {{(D_MAN_W-S_MAN_W){1'b0}}, ~e_zero, v[S_MAN_W-1:0]};
    d.exp = e_zero ? X_ONE : {{(XW-D_EXP_W){1'b0}}, e};
    if (e_zero && m_zero) begin
      d.flg = FLG_ZERO;
      d.exp = '0;
    end else if (e_ones && m_zero) begin
      d.flg = FLG_INF;
    end else if (e_ones) begin
      d.flg = FLG_NAN;
    end else if (e_zero) begin
      d.flg = FLG_DEN;
    end else begin
      d.flg = FLG_NORM;
    end
    return d;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OP_BITS-1:0] r_op;
  dec_t               r_a;
  dec_t               r_b;
  dec_t               w_dec_a;
  dec_t               w_dec_b;
  logic               w_accept;

  assign w_dec_a  = f_decode(in_a, in_op[1]);
  assign w_dec_b  = f_decode(in_b, in_op[1]);
  assign w_accept = in_valid & in_ready;

`ifdef FP_UNPACK_DENORM_NORM_EN
  logic w_fmt;
  logic w_hid_a;
  logic w_hid_b;
  logic w_pre_a;
  logic w_pre_b;
  logic w_shift_a;
  logic w_shift_b;
  logic w_norm_last;
  logic w_has_den;

  assign w_fmt     = r_op[1];
  assign w_hid_a   = w_fmt ? r_a.man[D_MAN_W]   : r_a.man[S_MAN_W];
  assign w_hid_b   = w_fmt ? r_b.man[D_MAN_W]   : r_b.man[S_MAN_W];
  assign w_pre_a   = w_fmt ? r_a.man[D_MAN_W-1] : r_a.man[S_MAN_W-1];
  assign w_pre_b   = w_fmt ? r_b.man[D_MAN_W-1] : r_b.man[S_MAN_W-1];
  // Only denormals shift. A zero has no set bit and must never be shifted.
  assign w_shift_a = (r_a.flg == FLG_DEN) & ~w_hid_a;
  assign w_shift_b = (r_b.flg == FLG_DEN) & ~w_hid_b;
  // This edge is the last one when every shifting operand will have its
  // hidden-bit position set after the shift.
  assign w_norm_last = (~w_shift_a | w_pre_a) & (~w_shift_b | w_pre_b);
  assign w_has_den   = (w_dec_a.flg == FLG_DEN) | (w_dec_b.flg == FLG_DEN);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_accept) begin
`ifdef FP_UNPACK_DENORM_NORM_EN
          w_state_nxt = w_has_den ? ST_NORM : ST_HOLD;
`else
          w_state_nxt = ST_HOLD;
`endif
        end else if (r_state == ST_HOLD && out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef FP_UNPACK_DENORM_NORM_EN
      ST_NORM: begin
        if (w_norm_last) w_state_nxt = ST_HOLD;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    out_valid = (r_state == ST_HOLD);
`ifdef FP_UNPACK_DENORM_NORM_EN
    in_ready  = rst_n & (r_state != ST_NORM) & (~out_valid | out_ready);
`else
    in_ready  = rst_n & (~out_valid | out_ready);
`endif
  end

  // Output data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= in_op;
      r_a  <= w_dec_a;
      r_b  <= w_dec_b;
    end
`ifdef FP_UNPACK_DENORM_NORM_EN
    else if (r_state == ST_NORM) begin
      if (w_shift_a) begin
        r_a.man <= {r_a.man[MW-2:0], 1'b0};
        r_a.exp <= r_a.exp - X_ONE;
      end
      if (w_shift_b) begin
        r_b.man <= {r_b.man[MW-2:0], 1'b0};
        r_b.exp <= r_b.exp - X_ONE;
      end
    end
`endif
  end

  assign out_op     = r_op;
  assign out_sign_a = r_a.sign;
  assign out_sign_b = r_b.sign;
  assign out_exp_a  = r_a.exp;
  assign out_exp_b  = r_b.exp;
  assign out_man_a  = r_a.man;
  assign out_man_b  = r_b.man;
  assign out_flg_a  = r_a.flg;
  assign out_flg_b  = r_b.flg;

endmodule
